keypad_scan_ctrl: RTL and testbench

Scan controller for the 4x4 matrix keypad on the display board. Drives one keypad row low at a time, samples the four column lines, and assembles a 16-bit key frame. It debounces across whole frames and presents a stable one-hot key vector. That vector is the input of the downstream one-hot-to-digit encoder, and a one-cycle `key_valid` strobe is issued on each new key press.

---
 rtl/keypad_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row low at a time, assembles a 16-bit frame,
// debounces across whole frames and presents a one-hot key vector with a press strobe.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        scan_en,
    input  logic [3:0]  col_i,
    output logic [3:0]  row_o,
    output logic [15:0] onehot,
    output logic [3:0]  key_index,
    output logic        key_valid,
    output logic        key_held
);

    localparam int unsigned    DivW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(SCAN_DIV - 1);
    localparam logic [3:0]     DebMax  = 4'(DEBOUNCE_SCANS);

    localparam logic [0:0] StScan = 1'b0;
    localparam logic [0:0] StEval = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [DivW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]      row_cnt_q, row_cnt_d;
    logic [15:0]     frame_raw_q, frame_raw_d;
    logic [15:0]     cand_q, cand_d;
    logic [3:0]      stable_cnt_q, stable_cnt_d;
    logic [15:0]     onehot_q, onehot_d;
    logic [3:0]      key_index_q, key_index_d;
    logic            key_valid_q, key_valid_d;
    logic            key_held_q, key_held_d;

    logic            sample;
    logic [4:0]      pop;
    logic [3:0]      enc;
    logic [3:0]      stable_nx;

    assign sample = (div_cnt_q == DivLast);

    // Popcount and bit position of the completed frame, used only in EVAL.
    always_comb begin
        pop = '0;
        enc = '0;
        for (int i = 0; i < 16; i++) begin
            pop = pop + 5'(frame_raw_q[i]);
            if (frame_raw_q[i]) begin
                enc = 4'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        div_cnt_d    = div_cnt_q;
        row_cnt_d    = row_cnt_q;
        frame_raw_d  = frame_raw_q;
        cand_d       = cand_q;
        stable_cnt_d = stable_cnt_q;
        onehot_d     = onehot_q;
        key_index_d  = key_index_q;
        key_valid_d  = 1'b0;
        key_held_d   = key_held_q;
        stable_nx    = stable_cnt_q;

        if (!scan_en) begin
            // Halting discards the partial frame and any pending evaluation.
            state_d     = StScan;
            div_cnt_d   = '0;
            row_cnt_d   = '0;
            frame_raw_d = '0;
        end else begin
            if (sample) begin
                div_cnt_d = '0;
                row_cnt_d = row_cnt_q + 2'd1;
                for (int c = 0; c < 4; c++) begin
                    frame_raw_d[{row_cnt_q, 2'(c)}] = ~col_i[c];
                end
                state_d = (row_cnt_q == 2'd3) ? StEval : StScan;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
                state_d   = StScan;
            end

            if (state_q == StEval) begin
                if (pop >= 5'd2) begin
                    stable_cnt_d = '0;
                end else begin
                    if (frame_raw_q == cand_q) begin
                        stable_nx = (stable_cnt_q >= DebMax) ? DebMax : stable_cnt_q + 4'd1;
                    end else begin
                        cand_d    = frame_raw_q;
                        stable_nx = 4'd1;
                    end
                    stable_cnt_d = stable_nx;
                    if (stable_nx == DebMax && frame_raw_q != onehot_q) begin
                        onehot_d   = frame_raw_q;
                        key_held_d = |frame_raw_q;
                        if (|frame_raw_q) begin
                            key_index_d = enc;
                            key_valid_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StScan;
            div_cnt_q    <= '0;
            row_cnt_q    <= '0;
            frame_raw_q  <= '0;
            cand_q       <= '0;
            stable_cnt_q <= '0;
            onehot_q     <= '0;
            key_index_q  <= '0;
            key_valid_q  <= 1'b0;
            key_held_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_cnt_q    <= div_cnt_d;
            row_cnt_q    <= row_cnt_d;
            frame_raw_q  <= frame_raw_d;
            cand_q       <= cand_d;
            stable_cnt_q <= stable_cnt_d;
            onehot_q     <= onehot_d;
            key_index_q  <= key_index_d;
            key_valid_q  <= key_valid_d;
            key_held_q   <= key_held_d;
        end
    end

    assign row_o     = scan_en ? ~(4'b0001 << row_cnt_q) : 4'hF;
    assign onehot    = onehot_q;
    assign key_index = key_index_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a physical keypad model drives the columns, and a frame-level
// reference model predicts outputs every cycle; table records and corner sequences add checks.
module tb_keypad_scan_ctrl;

    localparam int SD  = 4;
    localparam int DEB = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        scan_en;
    logic [3:0]  col_i;
    logic [3:0]  row_o;
    logic [15:0] onehot;
    logic [3:0]  key_index;
    logic        key_valid;
    logic        key_held;

    logic [15:0] pressed;

    keypad_scan_ctrl #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_SCANS (DEB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scan_en   (scan_en),
        .col_i     (col_i),
        .row_o     (row_o),
        .onehot    (onehot),
        .key_index (key_index),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    // Pressed key shorts its row line to its column line.
    always_comb begin
        col_i = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !row_o[r]) col_i[c] = 1'b0;
            end
        end
    end

    // Reference model state: scan time, pending frame, debouncer, outputs.
    int          m_t;
    logic        m_pend;
    logic [15:0] m_frame;
    logic [15:0] m_cand;
    int          m_stable;
    logic [15:0] m_onehot;
    logic [3:0]  m_idx;
    logic        m_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_pend = 0; m_frame = '0; m_cand = '0; m_stable = 0;
        m_onehot = '0; m_idx = '0; m_valid = 0;
    endtask

    task automatic model_eval(input logic [15:0] fr);
        if ($countones(fr) >= 2) begin
            m_stable = 0;
        end else begin
            if (fr == m_cand) begin
                m_stable = (m_stable + 1 > DEB) ? DEB : m_stable + 1;
            end else begin
                m_cand   = fr;
                m_stable = 1;
            end
            if (m_stable == DEB && fr != m_onehot) begin
                m_onehot = fr;
                if (fr != 0) begin
                    for (int i = 0; i < 16; i++) if (fr[i]) m_idx = 4'(i);
                    m_valid = 1;
                end
            end
        end
    endtask

    // One clock: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        logic        en;
        logic [15:0] pk;
        logic [3:0]  one;
        logic [3:0]  exp_row;
        int          r;
        en  = scan_en;
        pk  = pressed;
        one = 4'b0001;
        @(posedge clk);
        m_valid = 0;
        if (!en) begin
            m_t = 0; m_pend = 0; m_frame = '0;
        end else begin
            if (m_pend) begin
                model_eval(m_frame);
                m_pend = 0;
            end
            if (m_t % SD == SD - 1) begin
                r = (m_t / SD) % 4;
                for (int c = 0; c < 4; c++) m_frame[r*4+c] = pk[r*4+c];
                if (r == 3) m_pend = 1;
            end
            m_t++;
        end
        #1;
        exp_row = en ? ~(one << ((m_t / SD) % 4)) : 4'hF;
        check("row_o", 32'(row_o), 32'(exp_row));
        check("onehot", 32'(onehot), 32'(m_onehot));
        check("key_index", 32'(key_index), 32'(m_idx));
        check("key_valid", 32'(key_valid), 32'(m_valid));
        check("key_held", 32'(key_held), 32'(|m_onehot));
        if (key_valid) pulses++;
    endtask

    typedef struct {
        logic [15:0] keys;
        int          frames;
        logic [15:0] exp_onehot;
        logic [3:0]  exp_idx;
        logic        exp_held;
        int          exp_pulses;
    } vec_t;

    vec_t vecs[16];

    initial begin
        logic [3:0] exp_rows[4];
        int         n;

        vecs[0]  = '{16'h0000, 2, 16'h0000, 4'd0,  1'b0, 0};
        vecs[1]  = '{16'h0200, 3, 16'h0200, 4'd9,  1'b1, 1};  // clean press
        vecs[2]  = '{16'h0200, 2, 16'h0200, 4'd9,  1'b1, 0};
        vecs[3]  = '{16'h0000, 2, 16'h0200, 4'd9,  1'b1, 0};
        vecs[4]  = '{16'h0000, 1, 16'h0000, 4'd9,  1'b0, 0};  // release, no pulse
        vecs[5]  = '{16'h0021, 3, 16'h0000, 4'd9,  1'b0, 0};  // multi-press invalid
        vecs[6]  = '{16'h0001, 3, 16'h0001, 4'd0,  1'b1, 1};
        vecs[7]  = '{16'h0008, 3, 16'h0008, 4'd3,  1'b1, 1};
        vecs[8]  = '{16'h1000, 3, 16'h1000, 4'd12, 1'b1, 1};  // direct change
        vecs[9]  = '{16'h0040, 1, 16'h1000, 4'd12, 1'b1, 0};  // bounce
        vecs[10] = '{16'h0000, 1, 16'h1000, 4'd12, 1'b1, 0};
        vecs[11] = '{16'h0040, 1, 16'h1000, 4'd12, 1'b1, 0};
        vecs[12] = '{16'h0000, 1, 16'h1000, 4'd12, 1'b1, 0};
        vecs[13] = '{16'h0040, 1, 16'h1000, 4'd12, 1'b1, 0};
        vecs[14] = '{16'h0040, 2, 16'h0040, 4'd6,  1'b1, 1};
        vecs[15] = '{16'h0000, 3, 16'h0000, 4'd6,  1'b0, 0};

        exp_rows[0] = 4'b1110; exp_rows[1] = 4'b1101;
        exp_rows[2] = 4'b1011; exp_rows[3] = 4'b0111;

        rst_n = 1'b0; scan_en = 1'b1; pressed = '0;
        model_reset();
        #1;
        check("reset row_o", 32'(row_o), 32'(4'b1110));
        check("reset onehot", 32'(onehot), 32'h0);
        check("reset key_valid", 32'(key_valid), 32'h0);
        check("reset key_held", 32'(key_held), 32'h0);
        check("reset key_index", 32'(key_index), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step();  // aligns record boundaries just after each EVAL

        foreach (vecs[i]) begin
            pressed = vecs[i].keys;
            pulses  = 0;
            repeat (16 * vecs[i].frames) step();
            check($sformatf("vec%0d onehot", i), 32'(onehot), 32'(vecs[i].exp_onehot));
            check($sformatf("vec%0d key_index", i), 32'(key_index), 32'(vecs[i].exp_idx));
            check($sformatf("vec%0d key_held", i), 32'(key_held), 32'(vecs[i].exp_held));
            check($sformatf("vec%0d pulses", i), 32'(pulses), 32'(vecs[i].exp_pulses));
        end

        // Scan disable mid-frame while a key is held.
        pressed = 16'h0200;
        repeat (16 * 3) step();
        check("pre-disable onehot", 32'(onehot), 32'h0200);
        repeat (6) step();
        scan_en = 1'b0;
        pulses  = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("disable row_o", 32'(row_o), 32'hF);
            check("disable onehot", 32'(onehot), 32'h0200);
        end
        scan_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check("resume row_o", 32'(row_o), 32'(exp_rows[((i + 1) / SD) % 4]));
        end
        repeat (16 * 4) step();
        check("resume onehot", 32'(onehot), 32'h0200);
        check("resume pulses", 32'(pulses), 32'h0);

        // Asynchronous reset mid-scan with a key accepted.
        repeat (7) step();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async rst row_o", 32'(row_o), 32'(4'b1110));
        check("async rst onehot", 32'(onehot), 32'h0);
        check("async rst key_valid", 32'(key_valid), 32'h0);
        check("async rst key_held", 32'(key_held), 32'h0);
        model_reset();
        pressed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            step();
            check("post-reset row_o", 32'(row_o), 32'(exp_rows[(i / SD) % 4]));
        end

        // Randomised segments against the reference model.
        for (int s = 0; s < 60; s++) begin
            n = $urandom_range(0, 9);
            if (n <= 2) begin
                pressed = '0;
            end else if (n <= 7) begin
                pressed = 16'h0001 << $urandom_range(0, 15);
            end else if (n == 8) begin
                pressed = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
            end else begin
                scan_en = 1'b0;
                repeat ($urandom_range(1, 8)) step();
                scan_en = 1'b1;
            end
            repeat ($urandom_range(10, 70)) step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
